// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg : shared types and helpers for the UART TX arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching upward from ptr_i
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  always_comb begin : p_pick
    logic [IW-1:0] idx;
    idx       = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter : shares one UART transmitter between N_REQ byte streams
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_CYCLES = 12 * cycles_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [BYTE_W*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [BYTE_W-1:0]         uart_data_send_o,
  output logic                      uart_ena_tx_o,
  input  logic                      uart_tx_done_i,
  output logic [$clog2(N_REQ)-1:0]  grant_id_o,
  output logic                      busy_o,
  output logic                      timeout_err_o
);

  localparam int IW   = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic              lock_q, lock_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              ena_q, ena_d;
  logic              terr_q, terr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              tx_done_q;

  logic [BYTE_W-1:0] bytes [N_REQ];
  logic [N_REQ-1:0]  rr_gnt;
  logic [IW-1:0]     rr_idx;
  logic              rr_any;
  logic              done_rise;
  logic [IW-1:0]     ptr_next;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign bytes[gi] = req_data_i[gi*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(
    .N(N_REQ)
  ) u_rr (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .gnt_o    (rr_gnt),
    .gnt_idx_o(rr_idx),
    .any_o    (rr_any)
  );

  assign done_rise = uart_tx_done_i & ~tx_done_q;
  assign ptr_next  = (grant_id_q == IW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    lock_d      = lock_q;
    data_d      = data_q;
    ena_d       = ena_q;
    terr_d      = 1'b0;
    wd_d        = wd_q;
    req_ready_o = '0;

    case (state_q)
      IDLE: begin
        req_ready_o = rr_gnt;
        if (rr_any) begin
          data_d     = bytes[rr_idx];
          grant_id_d = rr_idx;
          lock_d     = ~req_last_i[rr_idx];
          wd_d       = '0;
          ena_d      = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        // A completion landing on the final watchdog cycle is still a success.
        if (done_rise) begin
          ena_d = 1'b0;
          if (lock_q) begin
            state_d = HOLD;
          end else begin
            ptr_d   = ptr_next;
            state_d = IDLE;
          end
        end else if (wd_q == WD_LAST) begin
          ena_d   = 1'b0;
          terr_d  = 1'b1;
          lock_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      HOLD: begin
        req_ready_o[grant_id_q] = req_valid_i[grant_id_q];
        if (req_valid_i[grant_id_q]) begin
          data_d  = bytes[grant_id_q];
          lock_d  = ~req_last_i[grant_id_q];
          wd_d    = '0;
          ena_d   = 1'b1;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      lock_q     <= 1'b0;
      data_q     <= '0;
      ena_q      <= 1'b0;
      terr_q     <= 1'b0;
      wd_q       <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      lock_q     <= lock_d;
      data_q     <= data_d;
      ena_q      <= ena_d;
      terr_q     <= terr_d;
      wd_q       <= wd_d;
      tx_done_q  <= uart_tx_done_i;
    end
  end

  assign uart_data_send_o = data_q;
  assign uart_ena_tx_o    = ena_q;
  assign grant_id_o       = grant_id_q;
  assign busy_o           = (state_q != IDLE);
  assign timeout_err_o    = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter : scoreboard bench with a behavioural UART model
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 5208;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     data_send;
  logic           ena_tx;
  logic           tx_done = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;
  logic           terr;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ    (N),
    .CLK_FREQ (50_000_000),
    .BAUD_RATE(115200)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .uart_data_send_o(data_send),
    .uart_ena_tx_o   (ena_tx),
    .uart_tx_done_i  (tx_done),
    .grant_id_o      (grant_id),
    .busy_o          (busy),
    .timeout_err_o   (terr)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [$];
  logic [8:0] src_q [N][$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         m_dly    = 20;
  int         m_hold   = 5;
  bit         m_nodone = 1'b0;
  bit         m_busy   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push(input int i, input logic last, input logic [7:0] d);
    src_q[i].push_back({last, d});
  endtask

  task automatic expect_frame(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back('{id: id, data: d});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic flush_srcs();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  function automatic logic [31:0] out_vec();
    return {15'd0, req_ready, data_send, ena_tx, grant_id, busy, terr};
  endfunction

  task automatic wait_quiet(input string name, input int budget);
    int k;
    k = 0;
    while (!(!busy && !m_busy && !tx_done && srcs_empty() && exp_q.size() == 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_quiet"}, 32'(k < budget), 32'd1);
  endtask

  // Requester sources: present the head of each queue, pop on transfer.
  initial begin : driver
    logic [N-1:0] xfer;
    forever begin
      @(negedge clk);
      xfer = rst ? '0 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Behavioural UART: starts on ena_tx when idle, raises tx_done m_dly edges later.
  initial begin : uart_model
    int k;
    bit abort;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && ena_tx) begin
        m_busy = 1'b1;
        abort  = 1'b0;
        k      = 0;
        while (!abort && (m_nodone || k < m_dly)) begin
          @(posedge clk);
          #1;
          k++;
          if (rst || !ena_tx) abort = 1'b1;
        end
        if (!abort) begin
          tx_done = 1'b1;
          for (int h = 0; h < m_hold; h++) begin
            @(posedge clk);
            #1;
            if (rst) break;
          end
          tx_done = 1'b0;
        end
        m_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic       prev_ena;
    logic       prev_done;
    logic [7:0] cap;
    exp_t       e;
    prev_ena  = 1'b0;
    prev_done = 1'b0;
    cap       = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ena  = 1'b0;
        prev_done = tx_done;
      end else begin
        if (ena_tx && !prev_ena) begin
          cap = data_send;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: got byte 0x%0h from id %0d, required no frame", data_send, grant_id);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", 32'(data_send), 32'(e.data));
            check("frame_id", 32'(grant_id), 32'(e.id));
          end
        end
        if (tx_done && !prev_done && ena_tx) check("data_stable", 32'(data_send), 32'(cap));
        prev_ena  = ena_tx;
        prev_done = tx_done;
      end
    end
  end

  initial begin : guard
    #900_000;
    $display("FAIL global_timeout: got no finish, required finish before 900us");
    $fatal(1, "simulation time limit");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush_srcs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int  k;
    int  cnt;
    bit  seen;

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 32'd0);
    rst = 1'b0;

    // Single byte, latency of ready and ena_tx.
    @(negedge clk);
    push(0, 1'b1, 8'hA5);
    expect_frame(2'd0, 8'hA5);
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'b0001);
    check("t1_ena_before", 32'(ena_tx), 32'd0);
    @(negedge clk);
    check("t1_ena_after", 32'(ena_tx), 32'd1);
    check("t1_ready_send", 32'(req_ready), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_quiet("t1", 2000);
    check("t1_grant", 32'(grant_id), 32'd0);

    // All four requesters contending, byte-level round robin with wrap.
    do_reset();
    push(0, 1'b1, 8'h10); push(1, 1'b1, 8'h11); push(2, 1'b1, 8'h12);
    push(3, 1'b1, 8'h13); push(0, 1'b1, 8'h10);
    expect_frame(2'd0, 8'h10); expect_frame(2'd1, 8'h11); expect_frame(2'd2, 8'h12);
    expect_frame(2'd3, 8'h13); expect_frame(2'd0, 8'h10);
    wait_quiet("t2", 4000);
    check("t2_grant", 32'(grant_id), 32'd0);

    // Frame lock: req2 starves until req1's last byte completes.
    do_reset();
    push(1, 1'b0, 8'h31); push(1, 1'b0, 8'h32); push(1, 1'b1, 8'h33);
    push(2, 1'b1, 8'h44);
    expect_frame(2'd1, 8'h31); expect_frame(2'd1, 8'h32); expect_frame(2'd1, 8'h33);
    expect_frame(2'd2, 8'h44);
    wait_quiet("t3", 4000);
    check("t3_grant", 32'(grant_id), 32'd2);

    // Watchdog abort, then the next requester is served.
    do_reset();
    m_nodone = 1'b1;
    push(0, 1'b1, 8'h55); push(1, 1'b1, 8'h66);
    expect_frame(2'd0, 8'h55); expect_frame(2'd1, 8'h66);
    k = 0;
    while (!ena_tx && k < 100) begin @(negedge clk); k++; end
    cnt = 0;
    while (!terr && cnt < TMO + 100) begin @(negedge clk); cnt++; end
    check("t4_timeout_cycle", 32'(cnt), 32'(TMO));
    check("t4_ena_low", 32'(ena_tx), 32'd0);
    check("t4_next_ready", 32'(req_ready), 32'b0010);
    m_nodone = 1'b0;
    @(negedge clk);
    check("t4_pulse_width", 32'(terr), 32'd0);
    wait_quiet("t4", 2000);

    // tx_done rising exactly on the last watchdog cycle completes normally.
    do_reset();
    m_dly = TMO - 1;
    push(2, 1'b1, 8'h77);
    expect_frame(2'd2, 8'h77);
    seen = 1'b0;
    @(negedge clk);
    k = 0;
    while ((busy || k < 3) && k < TMO + 200) begin
      @(negedge clk);
      seen |= terr;
      k++;
    end
    check("t5_no_timeout", 32'(seen), 32'd0);
    check("t5_done", 32'(busy), 32'd0);
    m_dly = 20;
    wait_quiet("t5", 2000);

    // Reset while in HOLD; pointer (3 here) and lock must clear.
    push(3, 1'b0, 8'h99);
    expect_frame(2'd3, 8'h99);
    k = 0;
    while (!(busy && !ena_tx && !m_busy && exp_q.size() == 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t6_hold_reached", 32'(k < 2000), 32'd1);
    push(0, 1'b1, 8'hB0);
    repeat (2) @(negedge clk);
    check("t6_hold_starve", 32'(req_ready), 32'd0);
    #1;
    rst = 1'b1;
    flush_srcs();
    @(negedge clk);
    check("t6_hold_reset", out_vec(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    push(0, 1'b1, 8'hC0); push(3, 1'b1, 8'hC3);
    expect_frame(2'd0, 8'hC0); expect_frame(2'd3, 8'hC3);
    wait_quiet("t6a", 3000);

    // Reset while in SEND with the pointer at 2.
    push(1, 1'b1, 8'hE1);
    expect_frame(2'd1, 8'hE1);
    wait_quiet("t6b_pre", 2000);
    push(2, 1'b0, 8'h88); push(2, 1'b1, 8'h89);
    expect_frame(2'd2, 8'h88);
    k = 0;
    while (!ena_tx && k < 100) begin @(negedge clk); k++; end
    check("t6_send_reached", 32'(ena_tx), 32'd1);
    #1;
    rst = 1'b1;
    flush_srcs();
    @(negedge clk);
    check("t6_send_reset", out_vec(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    push(0, 1'b1, 8'hD0); push(3, 1'b1, 8'hD3);
    expect_frame(2'd0, 8'hD0); expect_frame(2'd3, 8'hD3);
    wait_quiet("t6b", 3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
